pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined multi-mode barrel shifter. It is the successor to the team's 8-bit combinational left shifter.
- Adds width/stage parametrisation, right/arithmetic/rotate modes, a zero flag, and one register per shift stage.
- Uses valid/ready handshakes on both sides, with full backpressure.
- Sits between an operand-issue stage and a result-writeback stage in datapath blocks needing one shift per cycle at high clock rate.

Parameters:
- data_width, 8, operand/result width in bits; power of two, at least 4.
- shift_len, 3, shift-amount width; must equal log2(data_width). Also the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  block accepts the operation this cycle
- in_data  input  data_width  operand
- in_bits  input  shift_len  shift amount, 0..data_width-1
- in_mode  input  2  operation: 0=SLL, 1=SRL, 2=SRA, 3=ROL
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- out_data  output  data_width  shifted result
- out_zero  output  1  high when out_data == 0

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n sampled at the clk edge).
- Reset state: all stage valid bits and all stage registers cleared. Therefore out_valid=0, out_data=0, out_zero=1. in_ready=1 during the cycle after reset is released.
- Reset mid-operation: every in-flight operation is discarded with no output. Operations presented while rst_n=0 are not accepted.
- Stages: stage k (k=0..shift_len-1) holds valid_k, data_k, the remaining shift bits and mode_k.
- Per-stage shift: stage k shifts its input by 2^k when shift bit k is 1, otherwise passes it through unchanged.
- SLL: zero-fill from the LSB.
- SRL: zero-fill from the MSB.
- SRA: fill from the MSB with the operand's original sign bit. The sign bit travels with the operation through the pipeline.
- ROL: bits leaving the MSB re-enter at the LSB.
- Output: out_data and out_valid come directly from the last stage's registers (no combinational path from in_data). out_zero is derived from the last stage's data.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Ready chain: ready_k = !valid_k || ready_(k+1). ready_(shift_len) = out_ready. in_ready = ready_0. This is a combinational path from out_ready to in_ready.
- Register update: stage k loads from stage k-1 (or from the input port for k=0) only when ready_k. Stage k's valid_k is set from the upstream valid at that point.
- Hold under backpressure: a stage that is not ready holds its contents. out_data, out_zero and out_valid stay stable while out_valid && !out_ready.
- Latency: exactly shift_len cycles from input transfer to out_valid, when unstalled.
- Throughput: one operation per cycle, with simultaneous input and output transfer in the same cycle.
- Ordering: strictly in order; no operation dropped or duplicated.
- Capacity: at most shift_len operations in flight. With out_ready held low, in_ready falls once all stages are valid.
- in_bits = 0: result equals the operand in all modes.
- in_mode: all four encodings are defined; no illegal values.
- Width rules: all arithmetic is on data_width bits. Bits shifted past either end are discarded, except in ROL.

Test Plan (data_width=8):
1. SLL 0x81 by 1, out_ready=1 -> out_valid exactly 3 cycles after accept, out_data=0x02, out_zero=0.
2. SRL 0x80 by 3 -> 0x10; SRA 0x80 by 3 -> 0xF0; SRA 0x40 by 6 -> 0x01; ROL 0x81 by 1 -> 0x03; ROL 0x96 by 4 -> 0x69; SLL 0x80 by 1 -> 0x00 with out_zero=1.
3. Eight back-to-back operations (SLL 0x01 by 0..7), out_ready=1 -> results 0x01,0x02,...,0x80 on eight consecutive cycles, in order; in_ready stays 1 throughout.
4. Backpressure: out_ready=0 while streaming 5 operations -> exactly 3 accepted, in_ready=0 afterwards, out_data stable. Release out_ready -> all 5 results delivered in order, none lost.
5. Random mode/amount/operand with random in_valid/out_ready toggling, 10k operations -> scoreboard against a reference model; zero mismatches, zero drops/duplicates.
6. Assert rst_n=0 for one cycle with 3 operations in flight -> next cycle out_valid=0, out_data=0, out_zero=1; subsequent operations produce only their own results.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROL), one register per 2^k
// shift stage, with valid/ready handshakes and full backpressure.

module pipelined_barrel_shifter_step #(
  parameter int W   = 8,
  parameter int AMT = 1
) (
  input  logic [W-1:0] data_i,
  input  logic         en_i,
  input  logic [1:0]   mode_i,
  input  logic         sign_i,
  output logic [W-1:0] data_o
);
  logic [W-1:0] fill;

  // SRA fill uses the operand's original sign, not this stage's MSB.
  assign fill = sign_i ? ~({W{1'b1}} >> AMT) : '0;

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (mode_i)
        2'd0:    data_o = data_i << AMT;
        2'd1:    data_o = data_i >> AMT;
        2'd2:    data_o = (data_i >> AMT) | fill;
        default: data_o = (data_i << AMT) | (data_i >> (W - AMT));
      endcase
    end
  end
endmodule

module pipelined_barrel_shifter #(
  parameter int data_width = 8,
  parameter int shift_len  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  input  logic [shift_len-1:0]  in_bits,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_zero
);
  localparam int W = data_width;
  localparam int S = shift_len;

  logic [S-1:0]         vld_q, sign_q, up_vld, up_sign, rdy;
  logic [S-1:0][W-1:0]  data_q, up_data, data_d;
  logic [S-1:0][S-1:0]  bits_q, up_bits;
  logic [S-1:0][1:0]    mode_q, up_mode;

  // Stage k is fed by stage k-1; stage 0 by the input port.
  assign up_vld  = {vld_q[S-2:0],  in_valid};
  assign up_data = {data_q[S-2:0], in_data};
  assign up_bits = {bits_q[S-2:0], in_bits};
  assign up_mode = {mode_q[S-2:0], in_mode};
  assign up_sign = {sign_q[S-2:0], in_data[W-1]};

  for (genvar k = 0; k < S; k++) begin : g_stage
    pipelined_barrel_shifter_step #(.W(W), .AMT(1 << k)) u_step (
      .data_i (up_data[k]),
      .en_i   (up_bits[k][k]),
      .mode_i (up_mode[k]),
      .sign_i (up_sign[k]),
      .data_o (data_d[k])
    );
  end

  // ready_k = !valid_k || ready_(k+1), unrolled: stage k can move unless it and
  // every stage downstream of it are full while the output is stalled.
  always_comb begin
    for (int k = 0; k < S; k++)
      rdy[k] = out_ready || !(&(vld_q | S'((1 << k) - 1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
      bits_q <= '0;
      mode_q <= '0;
      sign_q <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (rdy[k]) begin
          vld_q[k]  <= up_vld[k];
          data_q[k] <= data_d[k];
          bits_q[k] <= up_bits[k];
          mode_q[k] <= up_mode[k];
          sign_q[k] <= up_sign[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_zero  = (data_q[S-1] == '0);

  // Control fields of the final stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{bits_q[S-1], mode_q[S-1], sign_q[S-1]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (8-bit, 3 stages) with a short
// randomized scoreboard phase.

module tb_pipelined_barrel_shifter;
  localparam int W = 8;
  localparam int S = 3;
  localparam int N_RND = 300;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [W-1:0] in_data, out_data;
  logic [S-1:0] in_bits;
  logic [1:0]   in_mode;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.data_width(W), .shift_len(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bits   (in_bits),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-operand reference, independent of the staged decomposition.
  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] d,
                                         input logic [S-1:0] b);
    logic [2*W-1:0] dd;
    case (m)
      2'd0:    model = d << b;
      2'd1:    model = d >> b;
      2'd2:    model = W'($signed(d) >>> b);
      default: begin dd = {d, d} << b; model = dd[2*W-1:W]; end
    endcase
  endfunction

  // Issue one op into an empty pipe at a negedge, check latency and result.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [W-1:0] d,
                        input logic [S-1:0] b, input logic [W-1:0] exp);
    int lat;
    in_valid = 1'b1; in_mode = m; in_data = d; in_bits = b; out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 10);
    chk({tag, ".latency"}, 32'(lat), 32'(S));
    chk({tag, ".data"}, 32'(out_data), 32'(exp));
    chk({tag, ".zero"}, 32'(out_zero), 32'(exp == '0));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         r;
    int           acc, got, sent;
    logic [W-1:0] e;
    logic [W-1:0] q[$];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_bits = '0; in_mode = '0;
    repeat (3) @(negedge clk);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data", 32'(out_data), 32'd0);
    chk("reset.out_zero", 32'(out_zero), 32'd1);
    rst_n = 1'b1;
    #1 chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Single operations
    run_op("sll_81_1", 2'd0, 8'h81, 3'd1, 8'h02);
    run_op("srl_80_3", 2'd1, 8'h80, 3'd3, 8'h10);
    run_op("sra_80_3", 2'd2, 8'h80, 3'd3, 8'hF0);
    run_op("sra_40_6", 2'd2, 8'h40, 3'd6, 8'h01);
    run_op("rol_81_1", 2'd3, 8'h81, 3'd1, 8'h03);
    run_op("rol_96_4", 2'd3, 8'h96, 3'd4, 8'h69);
    run_op("sll_80_1", 2'd0, 8'h80, 3'd1, 8'h00);
    run_op("sra_90_5", 2'd2, 8'h90, 3'd5, 8'hFC);
    run_op("sra_b4_7", 2'd2, 8'hB4, 3'd7, 8'hFF);
    run_op("sra_a5_0", 2'd2, 8'hA5, 3'd0, 8'hA5);
    run_op("rol_01_7", 2'd3, 8'h01, 3'd7, 8'h80);
    run_op("srl_ff_7", 2'd1, 8'hFF, 3'd7, 8'h01);
    run_op("sll_5a_0", 2'd0, 8'h5A, 3'd0, 8'h5A);

    // Back-to-back: SLL 0x01 by 0..7, results on consecutive cycles
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c >= S && c < S + 8) begin
        chk("b2b.valid", 32'(out_valid), 32'd1);
        chk("b2b.data", 32'(out_data), 32'd1 << (c - S));
      end else begin
        chk("b2b.idle", 32'(out_valid), 32'd0);
      end
      if (c < 8) begin
        in_valid = 1'b1; in_mode = 2'd0; in_data = 8'h01; in_bits = S'(c);
        #1 chk("b2b.in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure: 5 ops offered with out_ready low, only S fit
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 5); in_mode = 2'd0; in_data = 8'h01; in_bits = S'(acc);
      #1 r = in_ready;
      @(negedge clk);
      if (r && in_valid) acc++;
    end
    in_valid = 1'b0;
    chk("bp.accepted", 32'(acc), 32'(S));
    #1 chk("bp.in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_data", 32'(out_data), 32'h01);
      chk("bp.hold_zero", 32'(out_zero), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      in_valid = (acc < 5); in_bits = S'(acc);
      #1;
      if (out_valid) begin
        chk("bp.order", 32'(out_data), 32'd1 << got);
        got++;
      end
      r = in_ready;
      @(negedge clk);
      if (r && in_valid) acc++;
    end
    in_valid = 1'b0;
    chk("bp.delivered", 32'(got), 32'd5);
    chk("bp.all_in", 32'(acc), 32'd5);
    #1 chk("bp.drained", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Random traffic against the reference model
    sent = 0; got = 0;
    for (int c = 0; c < 4000 && got < N_RND; c++) begin
      in_valid  = (sent < N_RND) && ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = W'($urandom);
      in_bits   = S'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("rnd.expected_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rnd.data", 32'(out_data), 32'(e));
          chk("rnd.zero", 32'(out_zero), 32'(e == '0));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_mode, in_data, in_bits));
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rnd.count", 32'(got), 32'(N_RND));
    chk("rnd.leftover", 32'(q.size()), 32'd0);
    repeat (S + 1) @(negedge clk);
    chk("rnd.no_extra", 32'(out_valid), 32'd0);

    // Reset with three ops in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_mode = 2'd0; in_data = 8'h11; in_bits = S'(c);
      @(negedge clk);
    end
    chk("rst.inflight", 32'(out_valid), 32'd1);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h01; in_bits = '0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_zero", 32'(out_zero), 32'd1);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst.quiet", 32'(out_valid), 32'd0);
    end
    run_op("rst.post", 2'd1, 8'hC0, 3'd2, 8'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
